// File: rtl/rx_frame_drain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rx_frame_drain_ctrl_pkg
// Shared definitions for the receive-frame drain sequencer:
//   - one-hot state encoding of the drain FSM
//   - bit positions of the fields inside the 28-bit frame-info word
//   - default watchdog length in clk cycles
// -----------------------------------------------------------------------------
package rx_frame_drain_ctrl_pkg;

   typedef enum logic [5:0] {
      ST_IDLE    = 6'b000001,
      ST_INFO    = 6'b000010,
      ST_FETCH   = 6'b000100,
      ST_WAIT    = 6'b001000,
      ST_PRESENT = 6'b010000,
      ST_FLUSH   = 6'b100000
   } state_t;

   // frame_info word layout: {byte count, millisecond stamp, 0.1 ms stamp}
   localparam int CNT_MSB = 27;
   localparam int CNT_LSB = 16;
   localparam int MS_MSB  = 15;
   localparam int MS_LSB  = 4;
   localparam int ACQ_MSB = 3;
   localparam int ACQ_LSB = 0;

   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

endpackage

// File: rtl/rx_drain_watchdog.sv
// -----------------------------------------------------------------------------
// rx_drain_watchdog
// Empty-FIFO watchdog for the drain sequencer. The counter is cleared whenever
// clr is high, otherwise advances by one on each inc cycle. expire is high
// while the count sits at TIMEOUT_CYCLES-1, i.e. during the TIMEOUT_CYCLES-th
// consecutive inc cycle after a clear.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   clr    in   clear the counter (has priority over inc)
//   inc    in   advance the counter
//   expire out  counter has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module rx_drain_watchdog
   import rx_frame_drain_ctrl_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 16'd1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + TW'(1);
      end
   end

   // The counter only climbs while the owner keeps inc high and clr low, so
   // it never runs past LAST: the owner leaves that state on expire.
   assign expire = (cnt == LAST);

endmodule

// File: rtl/rx_frame_drain_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_drain_ctrl
// Read-side sequencer for the receive core. For each completed frame it reads
// the frame-info register once, then performs exactly one FIFO read per byte
// and presents each byte on a valid/ready stream. An empty FIFO that persists
// for TIMEOUT_CYCLES while bytes are still owed aborts the frame and clears
// the FIFO.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable_i            allow a new frame to start (looked at in IDLE only)
//   frame_info_i        {count[27:16], ms stamp[15:4], 0.1 ms stamp[3:0]}
//   n_rd_frame_fifo_o   frame-info read strobe, active-low
//   rx_data_i           receive FIFO data, valid the cycle after n_rd_o low
//   rx_empty_i          receive FIFO empty flag
//   n_rd_o              receive FIFO read strobe, active-low
//   n_clr_o             receive FIFO clear strobe, active-low
//   hdr_info_o          frame info latched for the current frame
//   hdr_valid_o         one-cycle pulse in the first cycle hdr_info_o is new
//   m_data_o/m_valid_o/m_ready_i/m_last_o  output byte stream
//   bytes_left_o        bytes still owed in the current frame
//   busy_o              high whenever not IDLE
//   abort_cnt_o         aborted-frame count, saturating at 255
//   timeout_o           one-cycle pulse while the abort flush is issued
// -----------------------------------------------------------------------------
module rx_frame_drain_ctrl
   import rx_frame_drain_ctrl_pkg::*;
#(
   parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int          CNT_W          = 12
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic [27:0]      frame_info_i,
   output logic             n_rd_frame_fifo_o,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_empty_i,
   output logic             n_rd_o,
   output logic             n_clr_o,
   output logic [27:0]      hdr_info_o,
   output logic             hdr_valid_o,
   output logic [7:0]       m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic             m_last_o,
   output logic [CNT_W-1:0] bytes_left_o,
   output logic             busy_o,
   output logic [7:0]       abort_cnt_o,
   output logic             timeout_o
);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] bytes_left;
   logic [CNT_W-1:0] info_cnt;
   logic             wd_clr;
   logic             wd_inc;
   logic             wd_expire;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign info_cnt = CNT_W'(frame_info_i[CNT_MSB:CNT_LSB]);

   rx_drain_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .clr   (wd_clr),
      .inc   (wd_inc),
      .expire(wd_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Strobes are decoded from the current state and suppressed while rst is
   // high so that a reset cycle never touches the FIFO or frame-info register.
   always_comb begin
      state_nx          = state;
      n_rd_frame_fifo_o = 1'b1;
      n_rd_o            = 1'b1;
      n_clr_o           = 1'b1;
      timeout_o         = 1'b0;
      wd_clr            = 1'b1;
      wd_inc            = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE: begin
               if (enable_i && (info_cnt != '0)) begin
                  state_nx = ST_INFO;
               end
            end
            ST_INFO: begin
               n_rd_frame_fifo_o = 1'b0;
               state_nx          = ST_FETCH;
            end
            ST_FETCH: begin
               if (!rx_empty_i) begin
                  n_rd_o   = 1'b0;
                  state_nx = ST_WAIT;
               end else begin
                  wd_clr = 1'b0;
                  wd_inc = 1'b1;
                  if (wd_expire) begin
                     state_nx = ST_FLUSH;
                  end
               end
            end
            ST_WAIT: begin
               state_nx = ST_PRESENT;
            end
            ST_PRESENT: begin
               if (m_ready_i) begin
                  state_nx = (bytes_left == CNT_W'(1)) ? ST_IDLE : ST_FETCH;
               end
            end
            ST_FLUSH: begin
               n_clr_o   = 1'b0;
               timeout_o = 1'b1;
               state_nx  = ST_IDLE;
            end
            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end
   end

   // Frame registers: header latch, byte countdown, output byte slot, aborts.
   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_info_o  <= '0;
         hdr_valid_o <= 1'b0;
         m_data_o    <= '0;
         m_valid_o   <= 1'b0;
         m_last_o    <= 1'b0;
         bytes_left  <= '0;
         abort_cnt_o <= '0;
      end else begin
         hdr_valid_o <= (state == ST_INFO);
         case (state)
            ST_INFO: begin
               hdr_info_o <= {frame_info_i[CNT_MSB:CNT_LSB],
                              frame_info_i[MS_MSB:MS_LSB],
                              frame_info_i[ACQ_MSB:ACQ_LSB]};
               bytes_left <= info_cnt;
            end
            ST_WAIT: begin
               // FIFO data became valid this cycle, one after the read strobe.
               m_data_o  <= rx_data_i;
               m_valid_o <= 1'b1;
               m_last_o  <= (bytes_left == CNT_W'(1));
            end
            ST_PRESENT: begin
               if (m_ready_i) begin
                  m_valid_o <= 1'b0;
                  m_last_o  <= 1'b0;
                  if (bytes_left != '0) begin
                     bytes_left <= bytes_left - CNT_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               abort_cnt_o <= sat_inc8(abort_cnt_o);
               bytes_left  <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign bytes_left_o = bytes_left;
   assign busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_drain_ctrl.sv
module tb_rx_frame_drain_ctrl;

   localparam logic [15:0] TO = 16'd8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b0;
   logic [27:0] frame_info_i = '0;
   logic [7:0]  rx_data_i = '0;
   logic        rx_empty_i;
   logic        m_ready_i = 1'b0;
   logic        n_rd_frame_fifo_o, n_rd_o, n_clr_o, hdr_valid_o;
   logic [27:0] hdr_info_o;
   logic [7:0]  m_data_o, abort_cnt_o;
   logic        m_valid_o, m_last_o, busy_o, timeout_o;
   logic [11:0] bytes_left_o;

   always #5 clk = ~clk;

   rx_frame_drain_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(12)) dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .frame_info_i(frame_info_i),
      .n_rd_frame_fifo_o(n_rd_frame_fifo_o), .rx_data_i(rx_data_i),
      .rx_empty_i(rx_empty_i), .n_rd_o(n_rd_o), .n_clr_o(n_clr_o),
      .hdr_info_o(hdr_info_o), .hdr_valid_o(hdr_valid_o), .m_data_o(m_data_o),
      .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
      .bytes_left_o(bytes_left_o), .busy_o(busy_o), .abort_cnt_o(abort_cnt_o),
      .timeout_o(timeout_o)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int c0 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Receive FIFO: data appears the cycle after a read strobe.
   logic [7:0] fifo_mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign rx_empty_i = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (rst || !n_clr_o) begin
         rd_ptr <= wr_ptr;
      end else if (!n_rd_o && (wr_ptr != rd_ptr)) begin
         rx_data_i <= fifo_mem[rd_ptr % 1024];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Transaction-level model: expected headers and bytes in order, bytes owed,
   // abort count. Checked every cycle outside reset.
   logic [7:0]  exp_bytes[$];
   logic [27:0] exp_hdr[$];
   logic [7:0]  acc_log[$];
   int m_left = 0, m_abort = 0, m_cnt = 0, frame_reads = 0, nlow = 0;
   int cnt_info = 0, cnt_rd = 0, cnt_clr = 0, cnt_to = 0, cnt_hdr = 0;
   int cnt_acc = 0, cnt_last = 0, info_cyc = 0, to_cyc = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_left = 0;
         m_abort = 0;
         frame_reads = 0;
         exp_bytes.delete();
      end else begin
         if (!n_rd_frame_fifo_o) begin
            cnt_info++;
            info_cyc = cyc;
         end
         if (hdr_valid_o) begin
            cnt_hdr++;
            if (exp_hdr.size() == 0) fail_now("hdr_valid_without_frame");
            else begin
               chk("hdr_info", 32'(hdr_info_o), 32'(exp_hdr[0]));
               m_cnt = int'(exp_hdr[0][27:16]);
               void'(exp_hdr.pop_front());
               m_left = m_cnt;
               frame_reads = 0;
            end
         end
         nlow = int'(!n_rd_o) + int'(!n_rd_frame_fifo_o) + int'(!n_clr_o);
         chk("strobe_exclusive", 32'(nlow > 1), 32'd0);
         chk("bytes_left", 32'(bytes_left_o), 32'(m_left));
         chk("abort_cnt", 32'(abort_cnt_o), 32'(m_abort));
         chk("timeout_with_clr", 32'(timeout_o), 32'(!n_clr_o));
         if (!n_rd_o) begin
            cnt_rd++;
            frame_reads++;
            chk("over_read", 32'(frame_reads > m_cnt), 32'd0);
         end
         if (m_valid_o) begin
            if (exp_bytes.size() == 0) fail_now("byte_without_fifo_data");
            else chk("m_data", 32'(m_data_o), 32'(exp_bytes[0]));
            chk("m_last", 32'(m_last_o), 32'(m_left == 1));
            if (m_ready_i) begin
               cnt_acc++;
               if (m_last_o) cnt_last++;
               acc_log.push_back(m_data_o);
               if (exp_bytes.size() > 0) void'(exp_bytes.pop_front());
               if (m_left > 0) m_left--;
            end
         end
         if (timeout_o) begin
            cnt_to++;
            to_cyc = cyc;
            m_abort = (m_abort >= 255) ? 255 : m_abort + 1;
            m_left = 0;
            exp_bytes.delete();
         end
         if (!n_clr_o) cnt_clr++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr % 1024] = b;
      wr_ptr++;
      exp_bytes.push_back(b);
   endtask

   task automatic start_frame(input logic [27:0] info);
      bit ok;
      ok = 0;
      exp_hdr.push_back(info);
      frame_info_i = info;
      enable_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!n_rd_frame_fifo_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_now("info_strobe_timeout");
      c0 = cyc;
      tick();
      // Count 0 from here on: later changes must not disturb the latched frame.
      frame_info_i = 28'h0;
   endtask

   task automatic wait_idle(input int max, output int lat);
      lat = -1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (!busy_o) begin
            lat = cyc - c0;
            break;
         end
      end
      if (lat < 0) fail_now("idle_timeout");
   endtask

   task automatic wait_acc(input int target, input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (cnt_acc >= target) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_now("accept_timeout");
   endtask

   initial begin
      #1000000;
      $display("FAIL global_time_limit");
      $fatal(1, "time limit");
   end

   initial begin
      int lat, b_info, b_rd, b_clr, b_to, b_acc, b_last, b_hdr;
      logic [7:0] e1 [3];
      logic [7:0] e5 [3];
      bit ok;
      e1 = '{8'hA5, 8'h5A, 8'hC3};
      e5 = '{8'h11, 8'h22, 8'h33};

      // Reset values
      repeat (3) tick();
      chk("rst_strobes", 32'({n_rd_o, n_rd_frame_fifo_o, n_clr_o}), 32'h7);
      chk("rst_hdr_info", 32'(hdr_info_o), 32'h0);
      chk("rst_outputs", 32'({hdr_valid_o, m_valid_o, m_last_o, busy_o, timeout_o}), 32'h0);
      chk("rst_m_data", 32'(m_data_o), 32'h0);
      chk("rst_bytes_left", 32'(bytes_left_o), 32'h0);
      chk("rst_abort_cnt", 32'(abort_cnt_o), 32'h0);
      rst = 1'b0;
      tick();

      // Basic 3-byte frame
      m_ready_i = 1'b1;
      acc_log.delete();
      b_info = cnt_info; b_rd = cnt_rd; b_acc = cnt_acc; b_last = cnt_last; b_hdr = cnt_hdr;
      push(8'hA5); push(8'h5A); push(8'hC3);
      start_frame(28'h0031F47);
      wait_idle(40, lat);
      chk("t1_latency", 32'(lat), 32'd10);
      chk("t1_info_pulses", 32'(cnt_info - b_info), 32'd1);
      chk("t1_hdr_pulses", 32'(cnt_hdr - b_hdr), 32'd1);
      chk("t1_hdr_latched", 32'(hdr_info_o), 32'h0031F47);
      chk("t1_rd_pulses", 32'(cnt_rd - b_rd), 32'd3);
      chk("t1_bytes", 32'(cnt_acc - b_acc), 32'd3);
      chk("t1_last_count", 32'(cnt_last - b_last), 32'd1);
      for (int k = 0; k < 3; k++)
         chk("t1_byte_value", (acc_log.size() > k) ? 32'(acc_log[k]) : 32'hDEAD, 32'(e1[k]));

      // Same frame with a 5-cycle stall on byte 2
      acc_log.delete();
      b_rd = cnt_rd; b_acc = cnt_acc;
      push(8'hA5); push(8'h5A); push(8'hC3);
      start_frame(28'h0031F47);
      wait_acc(b_acc + 1, 20);
      m_ready_i = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_valid_o) begin ok = 1; break; end
         tick();
      end
      if (!ok) fail_now("t2_valid_timeout");
      lat = cnt_rd;
      repeat (5) tick();
      chk("t2_stall_data", 32'(m_data_o), 32'h5A);
      chk("t2_stall_valid", 32'(m_valid_o), 32'd1);
      chk("t2_no_read_in_stall", 32'(cnt_rd - lat), 32'd0);
      m_ready_i = 1'b1;
      wait_idle(40, lat);
      chk("t2_latency", 32'(lat), 32'd15);
      chk("t2_rd_pulses", 32'(cnt_rd - b_rd), 32'd3);
      for (int k = 0; k < 3; k++)
         chk("t2_byte_value", (acc_log.size() > k) ? 32'(acc_log[k]) : 32'hDEAD, 32'(e1[k]));

      // Count 2 with only one byte available -> abort
      acc_log.delete();
      b_rd = cnt_rd; b_acc = cnt_acc; b_last = cnt_last; b_to = cnt_to; b_clr = cnt_clr;
      push(8'h3C);
      start_frame(28'h0020AB1);
      wait_idle(40, lat);
      chk("t3_latency", 32'(lat), 32'd13);
      chk("t3_timeout_at", 32'(to_cyc - c0), 32'd12);
      chk("t3_timeouts", 32'(cnt_to - b_to), 32'd1);
      chk("t3_clears", 32'(cnt_clr - b_clr), 32'd1);
      chk("t3_bytes", 32'(cnt_acc - b_acc), 32'd1);
      chk("t3_rd_pulses", 32'(cnt_rd - b_rd), 32'd1);
      chk("t3_no_last", 32'(cnt_last - b_last), 32'd0);
      chk("t3_byte_value", (acc_log.size() > 0) ? 32'(acc_log[0]) : 32'hDEAD, 32'h3C);
      chk("t3_abort_cnt", 32'(abort_cnt_o), 32'd1);
      chk("t3_bytes_left", 32'(bytes_left_o), 32'd0);

      // Count 0 never starts a frame
      b_info = cnt_info; b_rd = cnt_rd; b_clr = cnt_clr;
      frame_info_i = 28'h000ABCD;
      enable_i = 1'b1;
      repeat (20) tick();
      chk("t4_no_info", 32'(cnt_info - b_info), 32'd0);
      chk("t4_no_rd", 32'(cnt_rd - b_rd), 32'd0);
      chk("t4_no_clr", 32'(cnt_clr - b_clr), 32'd0);
      chk("t4_idle", 32'(busy_o), 32'd0);

      // enable_i low holds off a pending frame; dropping it mid-frame is ignored
      acc_log.delete();
      enable_i = 1'b0;
      frame_info_i = 28'h0030000;
      push(8'h11); push(8'h22); push(8'h33);
      b_info = cnt_info; b_rd = cnt_rd; b_acc = cnt_acc; b_last = cnt_last;
      repeat (20) tick();
      chk("t5_no_info", 32'(cnt_info - b_info), 32'd0);
      chk("t5_no_rd", 32'(cnt_rd - b_rd), 32'd0);
      chk("t5_idle", 32'(busy_o), 32'd0);
      start_frame(28'h0030000);
      wait_acc(b_acc + 1, 20);
      enable_i = 1'b0;
      wait_idle(40, lat);
      chk("t5_latency", 32'(lat), 32'd10);
      chk("t5_bytes", 32'(cnt_acc - b_acc), 32'd3);
      chk("t5_last_count", 32'(cnt_last - b_last), 32'd1);
      for (int k = 0; k < 3; k++)
         chk("t5_byte_value", (acc_log.size() > k) ? 32'(acc_log[k]) : 32'hDEAD, 32'(e5[k]));

      // Reset while a byte is waiting in PRESENT
      m_ready_i = 1'b0;
      push(8'hA1); push(8'hB2); push(8'hC3);
      start_frame(28'h0030000);
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_valid_o) begin ok = 1; break; end
         tick();
      end
      if (!ok) fail_now("t6_valid_timeout");
      rst = 1'b1;
      tick();
      chk("t6_strobes", 32'({n_rd_o, n_rd_frame_fifo_o, n_clr_o}), 32'h7);
      chk("t6_valid", 32'(m_valid_o), 32'd0);
      chk("t6_bytes_left", 32'(bytes_left_o), 32'd0);
      chk("t6_busy", 32'(busy_o), 32'd0);
      chk("t6_abort_cnt", 32'(abort_cnt_o), 32'd0);
      rst = 1'b0;
      m_ready_i = 1'b1;
      enable_i = 1'b1;
      repeat (5) tick();
      chk("t6_stays_idle", 32'(busy_o), 32'd0);

      // 256 forced aborts -> counter saturates
      b_to = cnt_to;
      for (int i = 0; i < 256; i++) begin
         start_frame({12'd1, 12'(i), 4'h5});
         wait_idle(40, lat);
         chk("t7_latency", 32'(lat), 32'd10);
         chk("t7_abort_cnt", 32'(abort_cnt_o), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      end
      chk("t7_timeouts", 32'(cnt_to - b_to), 32'd256);
      chk("t7_saturated", 32'(abort_cnt_o), 32'd255);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
